// File: rtl/adc_capture_ring.sv
// -----------------------------------------------------------------------------
// adc_capture_ring
//
// Capture engine for the ADC clock domain. It sits after the IDDR/deserialiser
// stage and writes every valid sample word into a circular BRAM region. The
// captured window holds up to pre_len words of history before the trigger,
// followed by post_len words that start with the trigger word. When a capture
// finishes, o_start_addr gives the ring address of the oldest word in the
// window. Software uses it to unwrap the ring.
//
// BRAM word layout: {zero pad, overrange[NUM_CH-1:0], samples[NUM_CH*SAMPLE_W-1:0]}
// Channel 0 sits in the LSBs.
//
// Parameters
//   NUM_CH    channels per sample word
//   SAMPLE_W  bits per channel sample
//   ADDR_W    ring address width (depth = 2**ADDR_W words)
//   BRAM_DW   BRAM data width, must be >= NUM_CH*(SAMPLE_W+1)
//
// Ports
//   clk, rst_n     sample clock (rising edge), async active-low reset
//   i_arm          one-cycle pulse that starts a capture (IDLE/DONE only)
//   i_abort        return to IDLE on the next cycle; wins over arm and trigger
//   i_trig         synchronised trigger level; its rising edge is used
//   i_pre_len      pre-trigger words to keep
//   i_post_len     post-trigger words, including the trigger word
//   i_din_valid    i_din / i_or carry a sample this cycle
//   i_din, i_or    packed samples and per-channel overrange flags
//   o_bram_addr/o_bram_data/o_bram_we   registered BRAM write port
//   o_busy         high in PRE_FILL, ARMED and POST
//   o_done         high in DONE (held until the next arm or abort)
//   o_cfg_err      sticky: the last arm was rejected for bad lengths
//   o_start_addr   ring address of the oldest word in the captured window
//   o_or_seen      sticky: a written word carried an overrange flag
//
// Optional feature (define CAP_TEST_PATTERN_EN)
//   Adds input i_test_mode. While it is high, every channel field carries the
//   same SAMPLE_W-bit ramp and the overrange field is zero. The ramp restarts
//   at 0 on each accepted arm and advances once per accepted sample.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_capture_ring #(
  parameter int NUM_CH   = 1,
  parameter int SAMPLE_W = 12,
  parameter int ADDR_W   = 12,
  parameter int BRAM_DW  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_arm,
  input  logic                         i_abort,
  input  logic                         i_trig,
  input  logic [ADDR_W-1:0]            i_pre_len,
  input  logic [ADDR_W-1:0]            i_post_len,
  input  logic                         i_din_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   i_din,
  input  logic [NUM_CH-1:0]            i_or,
`ifdef CAP_TEST_PATTERN_EN
  input  logic                         i_test_mode,
`endif
  output logic [ADDR_W-1:0]            o_bram_addr,
  output logic [BRAM_DW-1:0]           o_bram_data,
  output logic                         o_bram_we,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_cfg_err,
  output logic [ADDR_W-1:0]            o_start_addr,
  output logic                         o_or_seen
);

  localparam int DIN_W     = NUM_CH * SAMPLE_W;
  localparam int PAYLOAD_W = NUM_CH * (SAMPLE_W + 1);
  // Counters and length sums use one extra bit so that a full ring
  // (2**ADDR_W words) can be represented without wrapping.
  localparam int CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] RING_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    wp;
  logic                 trig_q;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [ADDR_W-1:0]    pre_len_q, post_len_q;
  logic [ADDR_W-1:0]    start_nxt;
  logic                 cfg_err_nxt;
  logic                 arm_take;

  logic                 trig_edge;
  logic                 capturing;
  logic                 accept;
  logic [CNT_W-1:0]     len_sum;
  logic                 len_bad;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CNT_W-1:0]     pre_ext, post_ext;

  logic [DIN_W-1:0]     din_sel;
  logic [NUM_CH-1:0]    or_sel;
  logic [BRAM_DW-1:0]   data_word;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign trig_edge = i_trig & ~trig_q;
  assign capturing = (state == S_PRE_FILL) || (state == S_ARMED) || (state == S_POST);
  assign accept    = capturing & i_din_valid;

  // The length check is done at ADDR_W+1 bits. This lets pre+post == depth pass
  // and stops a sum that wraps past the ring from looking small.
  assign len_sum   = {1'b0, i_pre_len} + {1'b0, i_post_len};
  assign len_bad   = (i_post_len == '0) || (len_sum > RING_DEPTH);

  assign cnt_inc   = cnt + CNT_W'(1);
  assign pre_ext   = {1'b0, pre_len_q};
  assign post_ext  = {1'b0, post_len_q};

  assign o_busy    = capturing;
  assign o_done    = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Control FSM: next state and next values of the control registers
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first. A path that forgets to assign it
    // then keeps its old value and no latch is inferred.
    state_nxt   = state;
    cnt_nxt     = cnt;
    start_nxt   = o_start_addr;
    cfg_err_nxt = o_cfg_err;
    arm_take    = 1'b0;

    if (i_abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            if (len_bad) begin
              cfg_err_nxt = 1'b1;
            end else begin
              cfg_err_nxt = 1'b0;
              arm_take    = 1'b1;
              cnt_nxt     = '0;
              state_nxt   = (i_pre_len == '0) ? S_ARMED : S_PRE_FILL;
            end
          end
        end

        // Edges are ignored here on purpose, including one that lands in the
        // same cycle as the last history sample.
        S_PRE_FILL: begin
          if (accept) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == pre_ext) begin
              state_nxt = S_ARMED;
            end
          end
        end

        // The trigger word is written at the current wp. This holds whether it
        // is accepted in this cycle or is the next valid sample, because wp
        // only moves on an accepted sample. So the window start is known now.
        S_ARMED: begin
          if (trig_edge) begin
            start_nxt = wp - pre_len_q;
            if (accept) begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = (post_ext == CNT_W'(1)) ? S_DONE : S_POST;
            end else begin
              cnt_nxt   = '0;
              state_nxt = S_POST;
            end
          end
        end

        S_POST: begin
          if (accept) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == post_ext) begin
              state_nxt = S_DONE;
            end
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples values from before the edge, whatever order the statements are in.
    if (!rst_n) begin
      state        <= S_IDLE;
      wp           <= '0;
      trig_q       <= 1'b0;
      cnt          <= '0;
      pre_len_q    <= '0;
      post_len_q   <= '0;
      o_start_addr <= '0;
      o_cfg_err    <= 1'b0;
      o_or_seen    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      o_start_addr <= start_nxt;
      o_cfg_err    <= cfg_err_nxt;
      trig_q       <= i_trig;

      if (arm_take) begin
        pre_len_q  <= i_pre_len;
        post_len_q <= i_post_len;
      end

      // wp is free-running across captures. It wraps naturally at 2**ADDR_W.
      if (accept) begin
        wp <= wp + ADDR_W'(1);
      end

      // An arm only happens in IDLE/DONE, where nothing is accepted, so the
      // clear and the set can never collide.
      if (arm_take) begin
        o_or_seen <= 1'b0;
      end else if (accept && (or_sel != '0)) begin
        o_or_seen <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data source selection (live samples or test ramp)
  // ---------------------------------------------------------------------------
`ifdef CAP_TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] ramp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp <= '0;
    end else if (arm_take) begin
      ramp <= '0;
    end else if (accept) begin
      ramp <= ramp + SAMPLE_W'(1);
    end
  end

  always_comb begin
    din_sel = i_din;
    or_sel  = i_or;
    if (i_test_mode) begin
      din_sel = {NUM_CH{ramp}};
      or_sel  = '0;
    end
  end
`else
  always_comb begin
    din_sel = i_din;
    or_sel  = i_or;
  end
`endif

  // Unused upper bits are zero. This also works when the payload exactly
  // fills BRAM_DW.
  always_comb begin
    data_word                  = '0;
    data_word[PAYLOAD_W-1:0]   = {or_sel, din_sel};
  end

  // ---------------------------------------------------------------------------
  // Registered BRAM write port (one cycle after acceptance)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_bram_we   <= 1'b0;
      o_bram_addr <= '0;
      o_bram_data <= '0;
    end else begin
      o_bram_we <= accept;
      if (accept) begin
        o_bram_addr <= wp;
        o_bram_data <= data_word;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ring.sv
`timescale 1ns/1ps

module tb_adc_capture_ring;

  localparam int NC    = 2;
  localparam int SW    = 12;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NCYC  = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_arm, i_abort, i_trig, i_din_valid;
  logic [AW-1:0]   i_pre_len, i_post_len;
  logic [NC*SW-1:0] i_din;
  logic [NC-1:0]   i_or;
  logic [AW-1:0]   o_bram_addr;
  logic [DW-1:0]   o_bram_data;
  logic            o_bram_we, o_busy, o_done, o_cfg_err, o_or_seen;
  logic [AW-1:0]   o_start_addr;

  always #5 clk = ~clk;

  adc_capture_ring #(
    .NUM_CH(NC), .SAMPLE_W(SW), .ADDR_W(AW), .BRAM_DW(DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_arm        (i_arm),
    .i_abort      (i_abort),
    .i_trig       (i_trig),
    .i_pre_len    (i_pre_len),
    .i_post_len   (i_post_len),
    .i_din_valid  (i_din_valid),
    .i_din        (i_din),
    .i_or         (i_or),
`ifdef CAP_TEST_PATTERN_EN
    .i_test_mode  (1'b0),
`endif
    .o_bram_addr  (o_bram_addr),
    .o_bram_data  (o_bram_data),
    .o_bram_we    (o_bram_we),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_cfg_err    (o_cfg_err),
    .o_start_addr (o_start_addr),
    .o_or_seen    (o_or_seen)
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle stimulus for one capture (cycle 0 = first cycle after the arm)
  logic             s_vld [NCYC];
  logic             s_trg [NCYC];
  logic [NC*SW-1:0] s_din [NCYC];
  logic [NC-1:0]    s_or  [NCYC];

  // Write transactions as {addr, data}
  logic [AW+DW-1:0] obs_w[$];
  logic [AW+DW-1:0] exp_w[$];

  // Reference state kept at transaction level
  int        tb_wp;
  logic [AW-1:0] tb_start;
  logic      exp_done, exp_busy, exp_or;
  int        exp_trig_idx;
  logic      ab_busy, ab_done;

  always @(negedge clk) begin
    if (o_bram_we) obs_w.push_back({o_bram_addr, o_bram_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pack_word(input logic [NC-1:0] o, input logic [NC*SW-1:0] d);
    pack_word = {6'd0, o, d};
  endfunction

  task automatic drive_idle();
    i_arm = 1'b0; i_abort = 1'b0; i_trig = 1'b0; i_din_valid = 1'b0;
    i_din = '0; i_or = '0; i_pre_len = '0; i_post_len = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tb_wp = 0;
    tb_start = '0;
  endtask

  // vmode 0: continuous valid, 1: valid on even cycles, 2: random then continuous.
  // e1/e2: cycles where the trigger rises (held two cycles), -1 for none.
  // or_idx: index of the valid sample (counted from arm) that carries overrange.
  task automatic gen_stim(input int vmode, input int e1, input int e2, input int or_idx);
    int k;
    k = 0;
    for (int c = 0; c < NCYC; c++) begin
      case (vmode)
        0:       s_vld[c] = 1'b1;
        1:       s_vld[c] = ((c % 2) == 0);
        default: s_vld[c] = (c >= 32) ? 1'b1 : ($urandom_range(0, 9) < 7);
      endcase
      s_trg[c] = ((e1 >= 0) && (c == e1 || c == e1 + 1)) ||
                 ((e2 >= 0) && (c == e2 || c == e2 + 1));
      s_din[c] = (NC*SW)'($urandom());
      s_or[c]  = '0;
      if (s_vld[c] && k == or_idx) s_or[c] = NC'($urandom_range(1, 3));
      if (s_vld[c]) k++;
    end
  endtask

  // Arms a capture, plays the stimulus, then derives the expected writes from
  // the capture rules: history fills pre words, the first rising edge seen
  // after that selects the next valid sample as trigger word, and the capture
  // stops post words later.
  task automatic run_capture(input int pre, input int post, input int abort_c);
    int  k, t, wp0;
    logic prev;
    obs_w.delete();
    exp_w.delete();
    if (abort_c >= 0) s_vld[abort_c] = 1'b0;
    @(negedge clk);
    i_arm = 1'b1; i_pre_len = AW'(pre); i_post_len = AW'(post);
    i_trig = 1'b0; i_din_valid = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    i_arm = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      i_din_valid = s_vld[c];
      i_trig      = s_trg[c];
      i_din       = s_din[c];
      i_or        = s_or[c];
      i_abort     = (c == abort_c);
      @(negedge clk);
      if (c == abort_c) begin
        ab_busy = o_busy;
        ab_done = o_done;
      end
    end
    i_din_valid = 1'b0; i_trig = 1'b0; i_abort = 1'b0; i_or = '0;
    repeat (2) @(negedge clk);

    wp0 = tb_wp; k = 0; t = -1; exp_or = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      if (c == abort_c) break;
      prev = (c == 0) ? 1'b0 : s_trg[c-1];
      if (t < 0 && s_trg[c] && !prev && k >= pre) t = k;
      if (s_vld[c] && !(t >= 0 && k >= t + post)) begin
        exp_w.push_back({AW'(wp0 + k), pack_word(s_or[c], s_din[c])});
        if (s_or[c] != '0) exp_or = 1'b1;
        k++;
      end
    end
    exp_done     = (abort_c < 0) && (t >= 0) && (k == t + post);
    exp_busy     = (abort_c < 0) && !exp_done;
    if (t >= 0) tb_start = AW'(wp0 + t - pre);
    tb_wp        = (wp0 + k) % DEPTH;
    exp_trig_idx = t;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_bram_we, o_busy, o_done, o_cfg_err, o_or_seen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {o_bram_we, o_busy, o_done, o_cfg_err, o_or_seen});
    end
    checks++;
    if ({o_bram_addr, o_start_addr, o_bram_data} !== '0) begin
      errors++;
      $display("FAIL reset_values got addr=%h start=%h data=%h want 0", o_bram_addr, o_start_addr, o_bram_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_bram_we, o_busy, o_done} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle got we/busy/done=%b want 000", {o_bram_we, o_busy, o_done});
    end
    tb_wp = 0;
    tb_start = '0;
  endtask

  task automatic test_basic();
    apply_reset();
    gen_stim(0, 10, -1, -1);
    run_capture(4, 6, -1);
    checks++;
    if (obs_w.size() != 16) begin
      errors++; $display("FAIL basic_count got %0d want 16", obs_w.size());
    end
    checks++;
    if (obs_w.size() - exp_trig_idx != 6) begin
      errors++; $display("FAIL basic_post_writes got %0d want 6", obs_w.size() - exp_trig_idx);
    end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      checks++;
      if (obs_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL basic_write[%0d] got %h want %h", i, obs_w[i], exp_w[i]);
      end
    end
    checks++;
    if (o_start_addr !== AW'(6)) begin
      errors++; $display("FAIL basic_start got %0d want 6", o_start_addr);
    end
    checks++;
    if ({o_done, o_busy} !== 2'b10) begin
      errors++; $display("FAIL basic_done_busy got %b want 10", {o_done, o_busy});
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    gen_stim(0, 0, -1, -1);
    run_capture(0, 14, -1);
    checks++;
    if (obs_w.size() != 14) begin
      errors++; $display("FAIL wrap_setup_count got %0d want 14", obs_w.size());
    end
    gen_stim(0, 0, -1, -1);
    run_capture(0, 5, -1);
    checks++;
    if (obs_w.size() != 5) begin
      errors++; $display("FAIL wrap_count got %0d want 5", obs_w.size());
    end
    for (int i = 0; i < 5 && i < obs_w.size(); i++) begin
      logic [AW-1:0] want_a;
      want_a = AW'((14 + i) % DEPTH);
      checks++;
      if (obs_w[i][AW+DW-1:DW] !== want_a) begin
        errors++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, obs_w[i][AW+DW-1:DW], want_a);
      end
      checks++;
      if (obs_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL wrap_write[%0d] got %h want %h", i, obs_w[i], exp_w[i]);
      end
    end
    checks++;
    if (o_start_addr !== AW'(14)) begin
      errors++; $display("FAIL wrap_start got %0d want 14", o_start_addr);
    end
  endtask

  task automatic test_cfg_err();
    obs_w.delete();
    @(negedge clk);
    i_arm = 1'b1; i_pre_len = AW'(10); i_post_len = AW'(7);
    @(negedge clk);
    i_arm = 1'b0; i_din_valid = 1'b1;
    repeat (4) @(negedge clk);
    i_din_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_cfg_err, o_busy} !== 2'b10) begin
      errors++; $display("FAIL cfg_sum_reject got err/busy=%b want 10", {o_cfg_err, o_busy});
    end
    checks++;
    if (obs_w.size() != 0) begin
      errors++; $display("FAIL cfg_no_writes got %0d want 0", obs_w.size());
    end
    @(negedge clk);
    i_arm = 1'b1; i_pre_len = AW'(3); i_post_len = AW'(0);
    @(negedge clk);
    i_arm = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_cfg_err, o_busy} !== 2'b10) begin
      errors++; $display("FAIL cfg_post_zero got err/busy=%b want 10", {o_cfg_err, o_busy});
    end
    // pre + post exactly fills the ring: accepted, and the error clears
    gen_stim(0, 12, -1, -1);
    run_capture(10, 6, -1);
    checks++;
    if ({o_cfg_err, o_done} !== 2'b01) begin
      errors++; $display("FAIL cfg_full_ring got err/done=%b want 01", {o_cfg_err, o_done});
    end
    checks++;
    if (obs_w.size() != exp_w.size()) begin
      errors++; $display("FAIL cfg_full_count got %0d want %0d", obs_w.size(), exp_w.size());
    end
    checks++;
    if (o_start_addr !== tb_start) begin
      errors++; $display("FAIL cfg_full_start got %0d want %0d", o_start_addr, tb_start);
    end
  endtask

  task automatic test_pre_edge();
    // First edge at sample 3 of an 8-word history is ignored
    gen_stim(0, 3, 12, -1);
    run_capture(8, 4, -1);
    checks++;
    if (o_start_addr !== tb_start) begin
      errors++; $display("FAIL pre_edge_start got %0d want %0d", o_start_addr, tb_start);
    end
    checks++;
    if (obs_w.size() != 16) begin
      errors++; $display("FAIL pre_edge_count got %0d want 16", obs_w.size());
    end
    // Edge in the same cycle as the last history sample is ignored too
    gen_stim(0, 7, 14, -1);
    run_capture(8, 4, -1);
    checks++;
    if (o_start_addr !== tb_start) begin
      errors++; $display("FAIL pre_edge_done_cycle_start got %0d want %0d", o_start_addr, tb_start);
    end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      checks++;
      if (obs_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL pre_edge_write[%0d] got %h want %h", i, obs_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_valid_gaps();
    // Valid on even cycles; the edge lands on a valid cycle; overrange on a
    // post-trigger sample (trigger is sample 5, sample 7 flags)
    gen_stim(1, 10, -1, 7);
    run_capture(3, 5, -1);
    checks++;
    if (obs_w.size() != exp_w.size()) begin
      errors++; $display("FAIL gaps_count got %0d want %0d", obs_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      checks++;
      if (obs_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL gaps_write[%0d] got %h want %h", i, obs_w[i], exp_w[i]);
      end
    end
    checks++;
    if (o_or_seen !== 1'b1) begin
      errors++; $display("FAIL gaps_or_seen got %b want 1", o_or_seen);
    end
    // Edge on an idle cycle: trigger is the next valid sample; a new arm clears or_seen
    gen_stim(1, 11, -1, -1);
    run_capture(3, 5, -1);
    checks++;
    if (o_start_addr !== tb_start) begin
      errors++; $display("FAIL gaps_idle_edge_start got %0d want %0d", o_start_addr, tb_start);
    end
    checks++;
    if ({o_or_seen, o_done} !== 2'b01) begin
      errors++; $display("FAIL gaps_or_cleared got or/done=%b want 01", {o_or_seen, o_done});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int pre, post, e1, oi;
      pre  = $urandom_range(0, 8);
      post = $urandom_range(1, (16 - pre) < 10 ? (16 - pre) : 10);
      e1   = $urandom_range(0, 20);
      oi   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : -1;
      gen_stim(2, e1, 45, oi);
      run_capture(pre, post, -1);
      checks++;
      if (obs_w.size() != exp_w.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d want %0d", n, obs_w.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
        checks++;
        if (obs_w[i] !== exp_w[i]) begin
          errors++; $display("FAIL rand%0d_write[%0d] got %h want %h", n, i, obs_w[i], exp_w[i]);
        end
      end
      checks++;
      if ({o_start_addr, o_done, o_busy, o_or_seen} !== {tb_start, exp_done, exp_busy, exp_or}) begin
        errors++;
        $display("FAIL rand%0d_status got start=%0d done=%b busy=%b or=%b want start=%0d done=%b busy=%b or=%b",
                 n, o_start_addr, o_done, o_busy, o_or_seen, tb_start, exp_done, exp_busy, exp_or);
      end
    end
  endtask

  task automatic test_abort_and_reset();
    gen_stim(0, 5, -1, -1);
    run_capture(2, 10, 9);
    checks++;
    if ({ab_busy, ab_done} !== 2'b00) begin
      errors++; $display("FAIL abort_next_cycle got busy/done=%b want 00", {ab_busy, ab_done});
    end
    checks++;
    if (obs_w.size() != 9) begin
      errors++; $display("FAIL abort_count got %0d want 9", obs_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      checks++;
      if (obs_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL abort_write[%0d] got %h want %h", i, obs_w[i], exp_w[i]);
      end
    end
    checks++;
    if ({o_done, o_busy, o_start_addr} !== {2'b00, tb_start}) begin
      errors++; $display("FAIL abort_final got done/busy=%b start=%0d want 00 start=%0d", {o_done, o_busy}, o_start_addr, tb_start);
    end

    // Reset while ARMED and writing
    @(negedge clk);
    i_arm = 1'b1; i_pre_len = '0; i_post_len = AW'(5);
    @(negedge clk);
    i_arm = 1'b0; i_din_valid = 1'b1; i_din = (NC*SW)'($urandom()); i_or = 2'b01;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_bram_we} !== 2'b11) begin
      errors++; $display("FAIL armed_before_reset got busy/we=%b want 11", {o_busy, o_bram_we});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_bram_we, o_busy, o_done, o_cfg_err, o_or_seen, o_bram_addr, o_start_addr, o_bram_data} !== '0) begin
      errors++;
      $display("FAIL async_reset got we=%b busy=%b done=%b err=%b or=%b addr=%h start=%h data=%h want all 0",
               o_bram_we, o_busy, o_done, o_cfg_err, o_or_seen, o_bram_addr, o_start_addr, o_bram_data);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    tb_wp = 0;
    tb_start = '0;
    gen_stim(0, 0, -1, -1);
    run_capture(0, 3, -1);
    checks++;
    if (obs_w.size() != 3) begin
      errors++; $display("FAIL reset_wp_count got %0d want 3", obs_w.size());
    end
    for (int i = 0; i < 3 && i < obs_w.size(); i++) begin
      checks++;
      if (obs_w[i][AW+DW-1:DW] !== AW'(i)) begin
        errors++; $display("FAIL reset_wp_addr[%0d] got %0d want %0d", i, obs_w[i][AW+DW-1:DW], i);
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_wrap();
    test_cfg_err();
    test_pre_edge();
    test_valid_gaps();
    test_random();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
